// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: keeps the group PC, issues single-group IM requests,
// buffers returned groups in a small FIFO and hands the head to decode.
module instruction_fetch_unit #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int IPC           = 4,
  parameter int QUEUE_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          IM_req,
  output logic [ADDRESS_WIDTH-1:0]      IM_address,
  input  logic [IPC*DATA_WIDTH-1:0]     IM_data,
  input  logic                          IM_dataValid,
  output logic [IPC*DATA_WIDTH-1:0]     DEC_data,
  output logic [ADDRESS_WIDTH-1:0]      DEC_pc,
  output logic                          DEC_dataValid,
  input  logic                          DEC_ready,
  input  logic                          redirect,
  input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
  output logic [1:0]                    dbg_state
);

  localparam int GW    = IPC * DATA_WIDTH;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(IPC);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~(ADDRESS_WIDTH'(IPC - 1));
  localparam logic [CNT_W-1:0]         CNT_FULL   = CNT_W'(QUEUE_DEPTH);

  // Handshakes (valid/ready):
  //   IM side  : IM_req is a one-cycle strobe; the IM captures IM_address on that edge
  //              and answers later with a single IM_dataValid pulse, in order.
  //   DEC side : a group transfers on any rising edge where DEC_dataValid && DEC_ready,
  //              unless redirect is high, which flushes instead. DEC_data/DEC_pc are
  //              stable while DEC_dataValid is high and not accepted.
  // Debug state encoding on dbg_state: 0 = IDLE, 1 = WAIT, 2 = DROP.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [GW-1:0]              fifo_data_q [QUEUE_DEPTH];
  logic [GW-1:0]              fifo_data_d [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]   fifo_pc_q   [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]   fifo_pc_d   [QUEUE_DEPTH];

  logic im_req;
  logic do_push;
  logic do_pop;
  logic fifo_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  assign fifo_valid = (count_q != '0);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;

    // Reset gating keeps the strobe low while rst is held, even though IDLE/empty.
    im_req  = rst && (state_q == S_IDLE) && (count_q < CNT_FULL) && !redirect;
    do_push = (state_q == S_WAIT) && IM_dataValid && !redirect;
    do_pop  = fifo_valid && DEC_ready && !redirect;

    if (redirect) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        // A response arriving on the redirect edge is the one in flight; it is
        // consumed and thrown away, so there is nothing left to drop.
        S_WAIT:  state_d = IM_dataValid ? S_IDLE : S_DROP;
        S_DROP:  state_d = IM_dataValid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (im_req) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (IM_dataValid) state_d = S_IDLE;
        end
        S_DROP: begin
          if (IM_dataValid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (do_push) begin
        fifo_data_d[tail_q] = IM_data;
        fifo_pc_d[tail_q]   = req_pc_q;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign IM_req        = im_req;
  assign IM_address    = pc_q;
  assign DEC_dataValid = fifo_valid;
  assign DEC_data      = fifo_valid ? fifo_data_q[head_q] : '0;
  assign DEC_pc        = fifo_valid ? fifo_pc_q[head_q] : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a latency-configurable IM responder plus a queue-based
// model of the fetch/decode contract, driven by directed phases and a randomized phase.
module tb_instruction_fetch_unit;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int IPC = 4;
  localparam int QD  = 4;
  localparam int GW  = IPC * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          IM_req;
  logic [AW-1:0] IM_address;
  logic [GW-1:0] IM_data;
  logic          IM_dataValid;
  logic [GW-1:0] DEC_data;
  logic [AW-1:0] DEC_pc;
  logic          DEC_dataValid;
  logic          DEC_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [1:0]    dbg_state;

  instruction_fetch_unit #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IPC(IPC), .QUEUE_DEPTH(QD), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .IM_req(IM_req), .IM_address(IM_address), .IM_data(IM_data), .IM_dataValid(IM_dataValid),
    .DEC_data(DEC_data), .DEC_pc(DEC_pc), .DEC_dataValid(DEC_dataValid), .DEC_ready(DEC_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] salt;

  logic [GW-1:0] exp_q[$];      // groups decode should see, oldest first
  logic [AW-1:0] exp_pc_q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_req_pc;
  int            m_pend;        // 0: nothing outstanding, 1: live request, 2: response to discard

  logic [AW-1:0] im_addr_q[$];  // IM responder: accepted addresses and their due cycles
  int            im_due_q[$];
  int            last_due = 0;

  function automatic logic [GW-1:0] im_word(input logic [AW-1:0] a);
    logic [GW-1:0] w;
    for (int i = 0; i < IPC; i++) w[i*DW +: DW] = {a, 6'(i), 16'hBEEF} ^ salt;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = '0;
    m_req_pc = '0;
    m_pend   = 0;
    exp_q.delete();
    exp_pc_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a negedge; drives inputs, checks outputs, advances the model, ends at next negedge.
  task automatic step(input bit rdy, input bit redir_in, input logic [AW-1:0] rpc);
    bit            dv;
    bit            redir;
    bit            exp_req;
    logic [GW-1:0] d;
    logic [GW-1:0] data_exp;
    logic [AW-1:0] pc_exp;
    int            due;

    dv = 1'b0;
    d  = {$urandom, $urandom, $urandom, $urandom};
    if (im_addr_q.size() > 0 && cyc >= im_due_q[0]) begin
      dv = 1'b1;
      d  = im_word(im_addr_q[0]);
      void'(im_addr_q.pop_front());
      void'(im_due_q.pop_front());
    end
    // Redirect is never aimed at a pending discard that completes the same cycle.
    redir = redir_in && !(m_pend == 2 && dv);

    IM_dataValid = dv;
    IM_data      = d;
    DEC_ready    = rdy;
    redirect     = redir;
    redirect_pc  = rpc;
    #1;

    exp_req  = (m_pend == 0) && (exp_q.size() < QD) && !redir;
    pc_exp   = (exp_pc_q.size() != 0) ? exp_pc_q[0] : '0;
    data_exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("im_req",     GW'(IM_req),        GW'(exp_req));
    chk("im_address", GW'(IM_address),    GW'(m_pc));
    chk("dec_valid",  GW'(DEC_dataValid), GW'(exp_q.size() != 0));
    chk("dec_pc",     GW'(DEC_pc),        GW'(pc_exp));
    chk("dec_data",   DEC_data,           data_exp);
    chk("dbg_state",  GW'(dbg_state),     GW'(m_pend));

    if (IM_req === 1'b1) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      im_addr_q.push_back(IM_address);
      im_due_q.push_back(due);
    end

    if (redir) begin
      m_pc   = rpc & ~(AW'(IPC - 1));
      exp_q.delete();
      exp_pc_q.delete();
      m_pend = (m_pend != 0 && !dv) ? 2 : 0;
    end else begin
      if (exp_q.size() != 0 && rdy) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (dv && m_pend == 1) begin
        exp_q.push_back(d);
        exp_pc_q.push_back(m_req_pc);
      end
      if (dv && m_pend != 0) m_pend = 0;
      if (exp_req) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + AW'(IPC);
        m_pend   = 1;
      end
    end

    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    rst          = 1'b0;
    redirect     = 1'b0;
    DEC_ready    = 1'b0;
    IM_dataValid = 1'b0;
    #1;
    chk("rst_im_req",     GW'(IM_req),        '0);
    chk("rst_im_address", GW'(IM_address),    '0);
    chk("rst_dec_valid",  GW'(DEC_dataValid), '0);
    chk("rst_dec_pc",     GW'(DEC_pc),        '0);
    chk("rst_dec_data",   DEC_data,           '0);
    model_reset();
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    // A request abandoned by the reset is answered on the first cycle after release.
    if (im_due_q.size() > 0) im_due_q[0] = cyc;
    last_due = cyc;
  endtask

  task automatic step_until_issued(input string tag);
    int n;
    n = 0;
    while (m_pend != 1 && n < 20) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    chk(tag, GW'(m_pend == 1), GW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    salt         = $urandom;
    rst          = 1'b1;
    IM_data      = '0;
    IM_dataValid = 1'b0;
    DEC_ready    = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    #2;
    do_reset(2);

    // Streaming with a 1-cycle IM and decode always ready.
    lat_min = 1; lat_max = 1;
    repeat (12) step(1'b1, 1'b0, '0);

    // Back-pressure: FIFO fills to four groups and fetch stops, then drains and resumes.
    repeat (14) step(1'b0, 1'b0, '0);
    repeat (14) step(1'b1, 1'b0, '0);

    // Redirect while a request is outstanding; the late response must be dropped.
    lat_min = 3; lat_max = 3;
    step_until_issued("issue_before_redirect");
    step(1'b1, 1'b1, 10'h02B);
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b1, 1'b0, '0);

    // Redirect on the same edge as the response.
    step_until_issued("issue_before_same_cycle");
    step(1'b1, 1'b1, 10'h101);
    repeat (8) step(1'b1, 1'b0, '0);

    // PC wrap at the top of the address space.
    step_until_issued("issue_before_wrap");
    step(1'b1, 1'b1, 10'd1020);
    repeat (10) step(1'b1, 1'b0, '0);

    // Reset in the middle of an outstanding request.
    lat_min = 5; lat_max = 5;
    step_until_issued("issue_before_reset");
    step(1'b1, 1'b0, '0);
    do_reset(2);
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b1, 1'b0, '0);

    // Randomized traffic: variable IM latency, decode stalls, occasional redirects.
    lat_min = 1; lat_max = 3;
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, AW'($urandom));
    lat_min = 1; lat_max = 1;
    repeat (12) step(1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the superscalar core; the transmitting side of the DEC_data/DEC_dataValid interface consumed by the decode stage.
- Keeps the group program counter, issues one-group requests to the instruction memory (IM), and buffers returned IPC-wide groups in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake and flushes on a branch redirect.

Parameters:
- ADDRESS_WIDTH, 10, width of the instruction-word address (PC counts instructions, not bytes).
- DATA_WIDTH, 32, width of one instruction.
- IPC, 4, instructions per group; must be a power of two.
- QUEUE_DEPTH, 4, FIFO depth in groups; power of two, at least 2.
- RESET_PC, 0, PC after reset; must be IPC-aligned.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- IM_req  output  1  request strobe; IM samples IM_address when this is 1 at a rising edge.
- IM_address  output  ADDRESS_WIDTH  group base address (current PC).
- IM_data  input  IPC*DATA_WIDTH  returned group, instruction 0 in the LSBs.
- IM_dataValid  input  1  IM_data valid this cycle; responses return in order, at least 1 cycle after the request.
- DEC_data  output  IPC*DATA_WIDTH  FIFO head group, same packing as IM_data.
- DEC_pc  output  ADDRESS_WIDTH  base address of the head group.
- DEC_dataValid  output  1  FIFO non-empty.
- DEC_ready  input  1  decode accepts the head this cycle.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  ADDRESS_WIDTH  new PC; the low log2(IPC) bits are forced to 0.

Behaviour:

Reset (rst=0, async):
- pc=RESET_PC, FIFO empty (head=tail=count=0), state=IDLE.
- Outputs: IM_req=0, IM_address=RESET_PC, DEC_data=0, DEC_pc=0, DEC_dataValid=0.
- Reset asserted mid-request abandons the request. Any later IM_dataValid arriving while not in WAIT is ignored.

FSM states:
- IDLE: IM_req = (count<QUEUE_DEPTH) && !redirect, combinational. When IM_req=1: pc <= pc+IPC (modulo 2^ADDRESS_WIDTH, wraps to 0), state <= WAIT.
- WAIT: IM_req=0. On IM_dataValid: push {IM_data, pc_of_request} and go to IDLE. pc_of_request is held in a register captured at issue.
- DROP: IM_req=0. On IM_dataValid: discard the data and go to IDLE.

Redirect (highest priority, same edge):
- pc <= aligned redirect_pc; FIFO cleared (count=0); any pop or push that cycle is cancelled.
- State: IDLE->IDLE with no request that cycle; WAIT->DROP, or WAIT->IDLE if IM_dataValid is 1 the same cycle (that data is discarded); DROP->DROP with pc updated.

Output side:
- DEC_dataValid = (count!=0). DEC_data/DEC_pc = head entry when valid, 0 when empty.
- Pop when DEC_dataValid && DEC_ready && !redirect; head advances, wrapping at QUEUE_DEPTH.
- Push and pop in the same cycle leave count unchanged. Pushing into an empty FIFO makes DEC_dataValid 1 in the next cycle (1-cycle IM-to-decode latency).
- Overflow cannot occur: a request is issued only when count<QUEUE_DEPTH, and count cannot rise while the request is outstanding.
- Peak throughput: one group per 2 cycles with a 1-cycle IM. One outstanding request at most.

Test Plan:
- Reset, DEC_ready=1, IM answers 1 cycle after each request -> IM_address sequence 0,4,8,12; DEC_pc sequence 0,4,8,12 in order, data matches the IM model.
- DEC_ready=0 -> exactly 4 groups buffered (pc 0..12), then IM_req stays 0. Raise DEC_ready -> groups drain in order and fetch resumes at address 16.
- Redirect with redirect_pc=0x2B while in WAIT, IM responds 2 cycles later -> that response is dropped, FIFO empty, next IM_address=0x28, next DEC_pc=0x28.
- Redirect in the same cycle as IM_dataValid in WAIT -> data discarded, state IDLE, FIFO empty the next cycle.
- ADDRESS_WIDTH=10, pc=1020 -> request at address 1020 issues, next IM_address=0 (wrap).
- rst pulsed low mid-WAIT, IM_dataValid arrives after release -> response ignored; the first post-reset request is at RESET_PC and DEC_dataValid stays 0 until that request returns.
